// File: rtl/ysyx_24100006_mem_arbiter.sv
// Two-requester arbiter for the shared data memory port.
// The IFU (fetch, read-only) and the LSU (load/store) compete for one memory
// access unit. One transaction is outstanding at a time. The winner's request
// is registered and driven to memory. The response is then returned to the
// owner. A response timeout turns a hung memory into an error response.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction; arbitrate and accept one upstream request
// ISSUE     | mem_req_valid high, registered payload held until mem_req_ready
// WAIT_RESP | waiting for mem_resp_valid; timeout counter running
// RESPOND   | owner's resp_valid high until the owner's resp_ready
module ysyx_24100006_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [7:0]        lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_RESP = 2'd2;
  localparam logic [1:0] S_RESPOND   = 2'd3;

  logic [1:0]        state;
  logic              owner;     // 0 = IFU, 1 = LSU
  logic              last;      // last granted requester, same encoding
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              owner_resp_ready;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = ~last;
        grant_ifu = last;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready    = grant_ifu;
  assign lsu_req_ready    = grant_lsu;
  assign owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;

  // Both response ports share the single response register.
  assign ifu_resp_rdata = rdata;
  assign ifu_resp_err   = err;
  assign lsu_resp_rdata = rdata;
  assign lsu_resp_err   = err;

  // Transaction sequencer: grant, issue, wait (with timeout), respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      owner          <= 1'b0;
      last           <= 1'b0;
      cnt            <= '0;
      rdata          <= '0;
      err            <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= '0;
      mem_req_wmask  <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            owner         <= grant_lsu;
            last          <= grant_lsu;
            mem_req_valid <= 1'b1;
            // A fetch is always a plain read: no write data or byte lanes.
            mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
            mem_req_wen   <= grant_lsu & lsu_req_wen;
            mem_req_wdata <= grant_lsu ? lsu_req_wdata : '0;
            mem_req_wmask <= grant_lsu ? lsu_req_wmask : '0;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // A real response beats a timeout landing in the same cycle.
          if (mem_resp_valid) begin
            rdata          <= mem_resp_rdata;
            err            <= 1'b0;
            ifu_resp_valid <= ~owner;
            lsu_resp_valid <= owner;
            state          <= S_RESPOND;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            rdata          <= '0;
            err            <= 1'b1;
            ifu_resp_valid <= ~owner;
            lsu_resp_valid <= owner;
            state          <= S_RESPOND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESPOND: begin
          if (owner_resp_ready) begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Scoreboard bench for the memory arbiter. A round-robin reference model
// predicts the grant order and the responses. A memory model answers requests
// with programmable delays. A monitor checks every request and response the
// DUT presents against the predicted queues.
module tb_ysyx_24100006_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] KEY = 32'h5EAD_BEEF;  // memory returns addr ^ KEY

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  ysyx_24100006_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          who;     // 0 = IFU, 1 = LSU
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [31:0] rdata;
    logic        err;
    int          lat;     // cycles from upstream handshake to first resp_valid
  } txn_t;

  txn_t req_q[$];
  txn_t resp_q[$];
  txn_t cur_req, cur_resp;
  bit   in_req = 0, in_resp = 0;
  int   hs_cyc = 0, done_cnt = 0;
  int   n_checks = 0, n_fail = 0;
  bit   model_last = 0;

  int   req_wait = 0, resp_wait = 0, rdy_mode = 0;
  bit   no_resp = 0, late_en = 0;
  int   mphase = 0, mcnt = 0;
  logic [31:0] maddr;

  logic [31:0] pay_ia[2], pay_la[2], pay_lwd[2];
  logic        pay_lwe[2];
  logic [7:0]  pay_lm[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_up();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_ifu_resp_valid"}, ifu_resp_valid, 0);
    chk({tag, "_lsu_resp_valid"}, lsu_resp_valid, 0);
    chk({tag, "_ifu_req_ready"}, ifu_req_ready, 0);
    chk({tag, "_lsu_req_ready"}, lsu_req_ready, 0);
    chk({tag, "_mem_req_addr"}, mem_req_addr, 0);
    chk({tag, "_mem_req_wen"}, mem_req_wen, 0);
    chk({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    chk({tag, "_mem_req_wmask"}, mem_req_wmask, 0);
    chk({tag, "_resp_rdata"}, {ifu_resp_rdata, lsu_resp_rdata}, 0);
    chk({tag, "_resp_err"}, {ifu_resp_err, lsu_resp_err}, 0);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < 2; k++) begin
      pay_ia[k]  = $urandom;
      pay_la[k]  = $urandom;
      pay_lwd[k] = $urandom;
      pay_lwe[k] = 1'($urandom_range(0, 1));
      pay_lm[k]  = 8'($urandom);
    end
  endtask

  // Reference model: serve ni IFU and nl LSU requests that are all pending,
  // alternating on ties, and push the expected request and response of each.
  task automatic predict(input int ni, input int nl, input int rw, input int sw,
                         input bit nr, input int rm, input bit le);
    int ri, rl, ci, cl;
    bit w;
    txn_t t;
    req_wait = rw; resp_wait = sw; no_resp = nr; rdy_mode = rm; late_en = le;
    ri = ni; rl = nl; ci = 0; cl = 0;
    while (ri + rl > 0) begin
      if (ri > 0 && rl > 0) w = ~model_last;
      else w = (rl > 0);
      t.who = w;
      if (w) begin
        t.addr = pay_la[cl]; t.wen = pay_lwe[cl]; t.wdata = pay_lwd[cl]; t.wmask = pay_lm[cl];
        cl++; rl--;
      end else begin
        t.addr = pay_ia[ci]; t.wen = 1'b0; t.wdata = '0; t.wmask = '0;
        ci++; ri--;
      end
      t.rdata = nr ? 32'h0 : (t.addr ^ KEY);
      t.err   = nr;
      t.lat   = nr ? (3 + rw + TO) : (3 + rw + sw);
      req_q.push_back(t);
      resp_q.push_back(t);
      model_last = w;
    end
  endtask

  task automatic drive_round(input int ni, input int nl);
    int gi, gl, base, vcnt, budget;
    bit pi, pl;
    gi = 0; gl = 0; pi = 0; pl = 0; vcnt = 0; base = done_cnt;
    @(posedge clk); #1;
    ifu_req_valid = (ni > 0); ifu_req_addr = pay_ia[0];
    lsu_req_valid = (nl > 0); lsu_req_addr = pay_la[0];
    lsu_req_wen = pay_lwe[0]; lsu_req_wdata = pay_lwd[0]; lsu_req_wmask = pay_lm[0];
    for (budget = 0; budget < 400; budget++) begin
      #1;
      pi = ifu_req_valid && ifu_req_ready;
      pl = lsu_req_valid && lsu_req_ready;
      if (ifu_resp_valid || lsu_resp_valid) vcnt++;
      else vcnt = 0;
      case (rdy_mode)
        0: begin ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1; end
        1: begin
          ifu_resp_ready = ($urandom_range(0, 3) != 0);
          lsu_resp_ready = ($urandom_range(0, 3) != 0);
        end
        default: begin ifu_resp_ready = (vcnt > 3); lsu_resp_ready = (vcnt > 3); end
      endcase
      @(posedge clk); #1;
      if (pi) begin
        gi++;
        if (gi < ni) ifu_req_addr = pay_ia[gi];
        else begin ifu_req_valid = 1'b0; ifu_req_addr = $urandom; end
      end
      if (pl) begin
        gl++;
        if (gl < nl) begin
          lsu_req_addr = pay_la[gl]; lsu_req_wen = pay_lwe[gl];
          lsu_req_wdata = pay_lwd[gl]; lsu_req_wmask = pay_lm[gl];
        end else begin
          lsu_req_valid = 1'b0; lsu_req_addr = $urandom; lsu_req_wdata = $urandom;
          lsu_req_wmask = 8'($urandom); lsu_req_wen = 1'($urandom_range(0, 1));
        end
      end
      if (done_cnt - base >= ni + nl) break;
    end
    if (budget >= 400) begin
      chk("round_complete", done_cnt - base, ni + nl);
      finish_up();
    end
  endtask

  task automatic run_round(input int ni, input int nl, input int rw, input int sw,
                           input bit nr, input int rm, input bit le);
    predict(ni, nl, rw, sw, nr, rm, le);
    drive_round(ni, nl);
  endtask

  // Memory model: accept after req_wait cycles, answer resp_wait cycles after
  // WAIT_RESP entry, or never when no_resp is set. late_en injects stray
  // responses while the arbiter is presenting a response.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
      if (mphase == 0 && mem_req_valid) begin mphase = 1; mcnt = 0; end
      if (mphase == 1) begin
        if (mcnt >= req_wait) begin
          mem_req_ready = 1'b1; maddr = mem_req_addr; mcnt = 0;
          mphase = no_resp ? 0 : 2;
        end else mcnt++;
      end else if (mphase == 2) begin
        if (mcnt >= resp_wait) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = maddr ^ KEY; mphase = 0;
        end else mcnt++;
      end
      if (late_en && (ifu_resp_valid || lsu_resp_valid)) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: compare every presented request/response with the scoreboard.
  initial begin
    bit any_rv;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      any_rv = ifu_resp_valid || lsu_resp_valid;
      if (mem_req_valid || any_rv)
        chk("no_ready_when_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
      if (ifu_req_valid && lsu_req_valid)
        chk("single_grant", ifu_req_ready && lsu_req_ready, 0);
      if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) hs_cyc = cyc;
      if (mem_req_valid) begin
        if (!in_req) begin
          chk("req_expected", req_q.size() > 0, 1);
          if (req_q.size() > 0) cur_req = req_q.pop_front();
          in_req = 1;
        end
        chk("mem_req_addr", mem_req_addr, cur_req.addr);
        chk("mem_req_wen", mem_req_wen, cur_req.wen);
        chk("mem_req_wdata", mem_req_wdata, cur_req.wdata);
        chk("mem_req_wmask", mem_req_wmask, cur_req.wmask);
        if (mem_req_ready) in_req = 0;
      end
      if (any_rv) begin
        if (!in_resp) begin
          chk("resp_expected", resp_q.size() > 0, 1);
          if (resp_q.size() > 0) cur_resp = resp_q.pop_front();
          chk("resp_latency", cyc - hs_cyc, cur_resp.lat);
          in_resp = 1;
        end
        chk("resp_owner", {ifu_resp_valid, lsu_resp_valid}, cur_resp.who ? 2'b01 : 2'b10);
        chk("resp_rdata", cur_resp.who ? lsu_resp_rdata : ifu_resp_rdata, cur_resp.rdata);
        chk("resp_err", cur_resp.who ? lsu_resp_err : ifu_resp_err, cur_resp.err);
        if (cur_resp.who ? lsu_resp_ready : ifu_resp_ready) begin
          in_resp = 0;
          done_cnt++;
        end
      end
    end
  end

  initial begin
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    lsu_resp_ready = 0;
    rand_payload();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests from reset: LSU, IFU, LSU, IFU.
    run_round(2, 2, 0, 0, 0, 0, 0);

    // Single IFU read with zero-wait memory.
    pay_ia[0] = 32'h8000_0000;
    run_round(1, 0, 0, 0, 0, 0, 0);

    // LSU response held off 3 cycles while the IFU waits.
    rand_payload();
    run_round(1, 1, 0, 1, 0, 2, 0);

    // LSU write with mem_req_ready held low for 5 cycles.
    pay_la[0] = 32'h8000_0010; pay_lwd[0] = 32'h1234_5678; pay_lm[0] = 8'h0F; pay_lwe[0] = 1'b1;
    run_round(0, 1, 5, 0, 0, 0, 0);

    // Timeouts, with stray memory responses while the error is presented.
    rand_payload();
    run_round(1, 0, 0, 0, 1, 2, 1);
    run_round(0, 1, 2, 0, 1, 0, 1);
    // Response landing in the same cycle as the timeout wins.
    run_round(1, 0, 0, TO, 0, 0, 0);

    // Async reset while the LSU transaction sits in WAIT_RESP.
    rand_payload();
    pay_la[0] = $urandom | 32'h1;
    predict(0, 1, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    lsu_req_valid = 1'b1; lsu_req_addr = pay_la[0]; lsu_req_wen = pay_lwe[0];
    lsu_req_wdata = pay_lwd[0]; lsu_req_wmask = pay_lm[0];
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    req_q.delete(); resp_q.delete();
    in_req = 0; in_resp = 0; mphase = 0; model_last = 0;
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // After reset the LSU wins the first tie again.
    rand_payload();
    run_round(1, 1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int r = 0; r < 40; r++) begin
      int ni, nl;
      ni = $urandom_range(0, 2);
      nl = $urandom_range(0, 2);
      if (ni + nl == 0) nl = 1;
      rand_payload();
      run_round(ni, nl, $urandom_range(0, 3), $urandom_range(0, TO),
                ($urandom_range(0, 5) == 0), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    chk("req_queue_drained", req_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    finish_up();
  end

endmodule
